// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the streaming dot-product engine.
package dot_product_pkg;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_tag_t;

  function automatic int unsigned acc_width(input int unsigned lanes, input int unsigned dw,
                                            input int unsigned beats);
    return 2 * dw + $clog2(lanes) + $clog2(beats);
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// Balanced adder-tree reduction of LANES inputs with a single output register.
module dp_adder_tree
  import dot_product_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned IW     = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en_i,
  input  logic [LANES*IW-1:0]             in_data_i,
  input  beat_tag_t                       in_tag_i,
  output logic [IW+$clog2(LANES)-1:0]     out_sum_o,
  output beat_tag_t                       out_tag_o
);

  localparam int unsigned LEVELS = $clog2(LANES);
  localparam int unsigned OW     = IW + LEVELS;

  logic [OW-1:0] sum_q;
  beat_tag_t     tag_q;

  // Level 0 holds width-extended leaves; each further level halves the node count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [OW-1:0] s [LANES >> l];
    for (genvar j = 0; j < (LANES >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (SIGNED != 0) begin : g_sx
          assign s[j] = OW'($signed(in_data_i[lane_lo(j, IW) +: IW]));
        end else begin : g_zx
          assign s[j] = OW'(in_data_i[lane_lo(j, IW) +: IW]);
        end
      end else begin : g_add
        assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      tag_q <= '0;
    end else if (en_i) begin
      sum_q <= g_lvl[LEVELS].s[0];
      tag_q <= in_tag_i;
    end
  end

  assign out_sum_o = sum_q;
  assign out_tag_o = tag_q;

endmodule

// File: rtl/dot_product_stream.sv
// Streaming pipelined dot product: S1 multipliers, S2 adder tree, S3 accumulator/output.
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int unsigned LANES     = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [LANES*DW-1:0]                         in_a,
  input  logic [LANES*DW-1:0]                         in_b,
  input  logic                                        in_last,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [acc_width(LANES, DW, MAX_BEATS)-1:0]  out_data,
  output logic [$clog2(MAX_BEATS):0]                  out_beats,
  output logic                                        err_beats
);

  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned SUM_W = PW + $clog2(LANES);
  localparam int unsigned ACC_W = acc_width(LANES, DW, MAX_BEATS);
  localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic                  stall;
  logic [LANES*PW-1:0]   prod_d, prod_q;
  beat_tag_t             s1_tag_q, s2_tag;
  logic [SUM_W-1:0]      s2_sum;
  logic [ACC_W-1:0]      sum_ext, acc_sum, acc_d, acc_q;
  logic [CNT_W-1:0]      beats_n, cnt_d, cnt_q;
  logic                  err_d, err_q;
  logic                  out_valid_d, out_valid_q;
  logic [ACC_W-1:0]      out_data_d, out_data_q;
  logic [CNT_W-1:0]      out_beats_d, out_beats_q;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] a_l, b_l;
    logic [PW-1:0] ax, bx;
    assign a_l = in_a[lane_lo(g, DW) +: DW];
    assign b_l = in_b[lane_lo(g, DW) +: DW];
    if (SIGNED != 0) begin : g_sx
      assign ax = {{DW{a_l[DW-1]}}, a_l};
      assign bx = {{DW{b_l[DW-1]}}, b_l};
    end else begin : g_zx
      assign ax = {{DW{1'b0}}, a_l};
      assign bx = {{DW{1'b0}}, b_l};
    end
    assign prod_d[lane_lo(g, PW) +: PW] = ax * bx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q   <= '0;
      s1_tag_q <= '0;
    end else if (!stall) begin
      prod_q         <= prod_d;
      s1_tag_q.valid <= in_valid;
      s1_tag_q.last  <= in_valid && in_last;
    end
  end

  dp_adder_tree #(
    .LANES  (LANES),
    .IW     (PW),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .en_i      (in_ready),
    .in_data_i (prod_q),
    .in_tag_i  (s1_tag_q),
    .out_sum_o (s2_sum),
    .out_tag_o (s2_tag)
  );

  // A last beat closes the vector and zeroes the accumulator so the next beat starts fresh.
  always_comb begin
    if (SIGNED != 0) sum_ext = ACC_W'($signed(s2_sum));
    else             sum_ext = ACC_W'(s2_sum);
    acc_sum     = acc_q + sum_ext;
    beats_n     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_beats_d = '0;
    if (s2_tag.valid) begin
      if (s2_tag.last) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_sum;
        out_beats_d = beats_n;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = beats_n;
        if (cnt_q == CNT_MAX) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else if (!stall) begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign err_beats = err_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench: three configurations (unsigned, signed, MAX_BEATS=4) against a vector-level model.
module tb_dot_product_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [3];
  logic        in_valid [3];
  logic        in_last [3];
  logic        out_ready [3];
  logic [63:0] in_a [3];
  logic [63:0] in_b [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic        err [3];
  logic [22:0] od0, od1;
  logic [20:0] od2;
  logic [4:0]  ob0, ob1;
  logic [2:0]  ob2;

  dot_product_stream u_dut (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od0), .out_beats(ob0), .err_beats(err[0]));

  dot_product_stream #(.SIGNED(1)) u_sgn (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od1), .out_beats(ob1), .err_beats(err[1]));

  dot_product_stream #(.MAX_BEATS(4)) u_mb (
    .clk(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od2), .out_beats(ob2), .err_beats(err[2]));

  typedef struct { longint data; int beats; int cyc; } obs_t;
  typedef struct { longint data; int beats; } exp_t;
  obs_t obsq[$];
  exp_t expq[$];

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  bit sender_done;

  function automatic void push_obs(longint d, int b, int c);
    obs_t o;
    o.data = d; o.beats = b; o.cyc = c;
    obsq.push_back(o);
  endfunction

  always @(negedge clk) begin
    if (out_valid[0] && out_ready[0]) push_obs(longint'(od0), int'(ob0), cyc);
    if (out_valid[1] && out_ready[1]) push_obs(longint'(od1), int'(ob1), cyc);
    if (out_valid[2] && out_ready[2]) push_obs(longint'(od2), int'(ob2), cyc);
  end

  function automatic int accw(int k);
    return (k == 2) ? 21 : 23;
  endfunction

  function automatic int maxb(int k);
    return (k == 2) ? 4 : 16;
  endfunction

  // Plain per-lane arithmetic on integer operand values.
  function automatic longint beat_dot(logic [63:0] a, logic [63:0] b, bit s);
    longint t;
    longint av, bv;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      av = longint'(a[i*8 +: 8]);
      bv = longint'(b[i*8 +: 8]);
      if (s && av > 127) av = av - 256;
      if (s && bv > 127) bv = bv - 256;
      t = t + av * bv;
    end
    return t;
  endfunction

  function automatic void push_exp(int k, longint s, int n);
    exp_t e;
    longint one;
    one = 1;
    e.data  = s & ((one << accw(k)) - 1);
    e.beats = (n > maxb(k)) ? maxb(k) : n;
    expq.push_back(e);
  endfunction

  task automatic send_beat(input int k, input logic [63:0] a, input logic [63:0] b,
                           input logic last, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    in_a[k] = a; in_b[k] = b; in_last[k] = last; in_valid[k] = 1'b1;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (in_ready[k]) begin ok = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0; in_last[k] = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic send_vector(input int k, input int n, input bit last, input bit bubbles);
    longint s;
    logic [63:0] a, b;
    int c;
    s = 0;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = s + beat_dot(a, b, k == 1);
      send_beat(k, a, b, last && (i == n - 1), c);
      if (bubbles) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    if (last) push_exp(k, s, n);
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (obsq.size() < n && t < budget) begin @(posedge clk); #1; t++; end
    ok = (obsq.size() >= n);
  endtask

  task automatic clear_q();
    obsq.delete();
    expq.delete();
    timeouts = 0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]); end
      checks++;
      if (err[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d]: got %b expected 0", k, err[k]); end
      checks++;
      if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]); end
    end
    checks++;
    if (od0 !== 23'd0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", od0); end
    checks++;
    if (ob0 !== 5'd0) begin failures++; $display("FAIL reset_out_beats: got %0d expected 0", ob0); end
  endtask

  task automatic test_max_product();
    int c;
    bit ok;
    clear_q();
    send_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, c);
    wait_results(1, 20, ok);
    checks++;
    if (!ok || timeouts != 0) begin failures++; $display("FAIL max_timeout: got %0d results expected 1", obsq.size()); end
    else begin
      checks++;
      if (obsq[0].data !== 64'sd520200) begin failures++; $display("FAIL max_data: got %0d expected 520200", obsq[0].data); end
      checks++;
      if (obsq[0].beats !== 1) begin failures++; $display("FAIL max_beats: got %0d expected 1", obsq[0].beats); end
      checks++;
      if (obsq[0].cyc - c !== 3) begin failures++; $display("FAIL max_latency: got %0d expected 3", obsq[0].cyc - c); end
    end
  endtask

  task automatic test_two_beat();
    logic [63:0] a1;
    int c;
    bit ok;
    clear_q();
    for (int i = 0; i < 8; i++) a1[i*8 +: 8] = 8'(i + 1);
    send_beat(0, a1, 64'h0101_0101_0101_0101, 1'b0, c);
    send_beat(0, 64'h0202_0202_0202_0202, 64'h0202_0202_0202_0202, 1'b1, c);
    wait_results(1, 20, ok);
    checks++;
    if (!ok || timeouts != 0) begin failures++; $display("FAIL two_timeout: got %0d results expected 1", obsq.size()); end
    else begin
      checks++;
      if (obsq[0].data !== 64'sd68) begin failures++; $display("FAIL two_data: got %0d expected 68", obsq[0].data); end
      checks++;
      if (obsq[0].beats !== 2) begin failures++; $display("FAIL two_beats: got %0d expected 2", obsq[0].beats); end
    end
  endtask

  task automatic test_signed();
    int c;
    bit ok;
    clear_q();
    send_beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 1'b1, c);
    send_vector(1, 3, 1'b1, 1'b1);
    wait_results(2, 30, ok);
    checks++;
    if (!ok || timeouts != 0) begin failures++; $display("FAIL sgn_timeout: got %0d results expected 2", obsq.size()); end
    else begin
      checks++;
      if (obsq[0].data !== 64'sd8388592) begin failures++; $display("FAIL sgn_minus16: got %0h expected 7ffff0", obsq[0].data); end
      checks++;
      if (obsq[1].data !== expq[0].data) begin failures++; $display("FAIL sgn_random: got %0h expected %0h", obsq[1].data, expq[0].data); end
      checks++;
      if (obsq[1].beats !== 3) begin failures++; $display("FAIL sgn_beats: got %0d expected 3", obsq[1].beats); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_q();
    for (int v = 0; v < 8; v++) send_vector(0, 1, 1'b1, 1'b0);
    wait_results(8, 30, ok);
    checks++;
    if (!ok || timeouts != 0) begin failures++; $display("FAIL b2b_timeout: got %0d results expected 8", obsq.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obsq[i].data !== expq[i].data) begin failures++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, obsq[i].data, expq[i].data); end
        checks++;
        if (obsq[i].cyc !== obsq[0].cyc + i) begin failures++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, obsq[i].cyc, obsq[0].cyc + i); end
      end
    end
  endtask

  task automatic sender_bp();
    for (int v = 0; v < 4; v++) send_vector(0, $urandom_range(1, 3), 1'b1, 1'b1);
    sender_done = 1;
  endtask

  task automatic test_backpressure();
    logic [22:0] held;
    int t;
    bit ok;
    clear_q();
    sender_done = 0;
    out_ready[0] = 1'b0;
    fork
      sender_bp();
    join_none
    t = 0;
    while (!out_valid[0] && t < 40) begin @(negedge clk); t++; end
    checks++;
    if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_first_valid: got %b expected 1", out_valid[0]); end
    held = od0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready[0]); end
      checks++;
      if (od0 !== held) begin failures++; $display("FAIL bp_data_stable: got %0d expected %0d", od0, held); end
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    t = 0;
    while (!sender_done && t < 300) begin @(posedge clk); #1; t++; end
    wait_results(4, 30, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (!ok || !sender_done || timeouts != 0 || obsq.size() != 4) begin
      failures++; $display("FAIL bp_count: got %0d results expected 4", obsq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obsq[i].data !== expq[i].data) begin failures++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, obsq[i].data, expq[i].data); end
        checks++;
        if (obsq[i].beats !== expq[i].beats) begin failures++; $display("FAIL bp_beats[%0d]: got %0d expected %0d", i, obsq[i].beats, expq[i].beats); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_q();
    send_vector(2, 4, 1'b1, 1'b0);
    wait_results(1, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovf_exact_timeout: got %0d results expected 1", obsq.size()); end
    else begin
      checks++;
      if (obsq[0].data !== expq[0].data) begin failures++; $display("FAIL ovf_exact_data: got %0d expected %0d", obsq[0].data, expq[0].data); end
      checks++;
      if (obsq[0].beats !== 4) begin failures++; $display("FAIL ovf_exact_beats: got %0d expected 4", obsq[0].beats); end
    end
    checks++;
    if (err[2] !== 1'b0) begin failures++; $display("FAIL ovf_exact_err: got %b expected 0", err[2]); end

    send_vector(2, 5, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err[2] !== 1'b1) begin failures++; $display("FAIL ovf_err_set: got %b expected 1", err[2]); end
    checks++;
    if (obsq.size() != 1) begin failures++; $display("FAIL ovf_no_output: got %0d results expected 1", obsq.size()); end

    send_vector(2, 2, 1'b0, 1'b0);
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    checks++;
    if (err[2] !== 1'b0) begin failures++; $display("FAIL rst_err_clear: got %b expected 0", err[2]); end
    checks++;
    if (out_valid[2] !== 1'b0 || od2 !== 21'd0 || ob2 !== 3'd0) begin
      failures++; $display("FAIL rst_outputs: got valid=%b data=%0d beats=%0d expected 0", out_valid[2], od2, ob2);
    end

    clear_q();
    send_vector(2, 1, 1'b1, 1'b0);
    wait_results(1, 20, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!ok || obsq.size() != 1) begin failures++; $display("FAIL rst_single_count: got %0d results expected 1", obsq.size()); end
    else begin
      checks++;
      if (obsq[0].data !== expq[0].data) begin failures++; $display("FAIL rst_single_data: got %0d expected %0d", obsq[0].data, expq[0].data); end
      checks++;
      if (obsq[0].beats !== 1) begin failures++; $display("FAIL rst_single_beats: got %0d expected 1", obsq[0].beats); end
    end
    checks++;
    if (err[2] !== 1'b0) begin failures++; $display("FAIL rst_single_err: got %b expected 0", err[2]); end

    clear_q();
    send_vector(2, 6, 1'b1, 1'b1);
    wait_results(1, 40, ok);
    checks++;
    if (!ok || timeouts != 0) begin failures++; $display("FAIL sat_timeout: got %0d results expected 1", obsq.size()); end
    else begin
      checks++;
      if (obsq[0].data !== expq[0].data) begin failures++; $display("FAIL sat_data: got %0d expected %0d", obsq[0].data, expq[0].data); end
      checks++;
      if (obsq[0].beats !== 4) begin failures++; $display("FAIL sat_beats: got %0d expected 4", obsq[0].beats); end
    end
    checks++;
    if (err[2] !== 1'b1) begin failures++; $display("FAIL sat_err: got %b expected 1", err[2]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; in_last[k] = 1'b0; out_ready[k] = 1'b1;
      in_a[k] = '0; in_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    test_reset();
    test_max_product();
    test_two_beat();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
